// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared constants, register map and FSM states for spi_cfg_master
//   No ports. Imported by spi_cfg_rr_arbiter and spi_cfg_master.
package spi_cfg_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_W    = 16;
  localparam int WRITE_FLAG = 15;

  // Register map of the SPI register peripheral
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_MAX       = 7'h04;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/spi_cfg_rr_arbiter.sv
// rtl/spi_cfg_rr_arbiter.sv - combinational round-robin grant; pointer register lives in the parent
//   valid     in  N_REQ  request vector (already gated to zero when the master is not idle)
//   ptr       in  ID_W   index where the search starts
//   grant     out N_REQ  one-hot grant, zero when no valid
//   grant_idx out ID_W   index of the granted requester
//   any       out 1      some requester is granted
module spi_cfg_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    // Walk the requesters circularly starting at ptr; the first valid one wins.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// rtl/spi_cfg_master.sv - round-robin SPI write master emitting 16-bit {1,addr,data} frames
//   Optional build macro: SPI_CFG_ADDR_CHECK_EN (rejects addresses above ADDR_MAX, adds addr_err)
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/addr/data  per-requester write requests (7-bit addr, 8-bit data slices)
//   req_ready        one-hot accept pulse, addr/data captured in that cycle
//   busy             accept cycle through last GAP cycle
//   done, done_id    completion pulse in first GAP cycle with requester index
//   SCLK, nCS, COPI  SPI mode 0, MSB first (registered)
//   addr_err         (macro only) pulses with done for a rejected address
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [N_REQ-1:0]                            req_valid,
  input  logic [7*N_REQ-1:0]                          req_addr,
  input  logic [8*N_REQ-1:0]                          req_data,
  output logic [N_REQ-1:0]                            req_ready,
  output logic                                        busy,
  output logic                                        done,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] done_id,
  output logic                                        SCLK,
  output logic                                        nCS,
  output logic                                        COPI
`ifdef SPI_CFG_ADDR_CHECK_EN
  ,
  output logic                                        addr_err
`endif
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(CS_GAP * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(CS_GAP * CLK_DIV - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 sclk_q, sclk_d;
  logic                 ncs_q, ncs_d;
  logic                 copi_q, copi_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
`ifdef SPI_CFG_ADDR_CHECK_EN
  logic                 addr_err_q, addr_err_d;
`endif

  logic [N_REQ-1:0]     arb_valid;
  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 expired;

  // Arbitration only happens in IDLE; requests raised mid-frame simply wait.
  assign arb_valid = (state_q == IDLE) ? req_valid : '0;

  spi_cfg_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .valid     (arb_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign sel_addr = req_addr[ADDR_W*int'(grant_idx) +: ADDR_W];
  assign sel_data = req_data[DATA_W*int'(grant_idx) +: DATA_W];
  assign expired  = (cnt_q == '0);

  // Handshake outputs follow the arbiter so the grant and the capture share one cycle;
  // the SPI pins and done/done_id are all flops.
  assign req_ready = grant;
  assign busy      = (state_q != IDLE) || grant_any;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign SCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = copi_q;
`ifdef SPI_CFG_ADDR_CHECK_EN
  assign addr_err  = addr_err_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = expired ? cnt_q : cnt_q - 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef SPI_CFG_ADDR_CHECK_EN
    addr_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          ptr_d   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
          id_d    = grant_idx;
          shift_d = {1'b1, sel_addr, sel_data};
          bit_d   = 4'd0;
          cnt_d   = CNT_DIV;
          state_d = SETUP;
`ifdef SPI_CFG_ADDR_CHECK_EN
          // Out-of-map writes are acknowledged but never reach the bus.
          if (sel_addr > ADDR_MAX) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            done_id_d  = grant_idx;
            addr_err_d = 1'b1;
          end
`endif
        end
      end
      SETUP: begin
        if (expired) begin
          state_d = HIGH;
          cnt_d   = CNT_DIV;
        end
      end
      HIGH: begin
        if (expired) begin
          cnt_d = CNT_DIV;
          // bit_q is the index of the bit just clocked; after bit 15 the frame is complete.
          if (bit_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (expired) begin
          state_d = HIGH;
          cnt_d   = CNT_DIV;
        end
      end
      HOLD: begin
        if (expired) begin
          state_d   = GAP;
          cnt_d     = CNT_GAP;
          done_d    = 1'b1;
          done_id_d = id_q;
        end
      end
      GAP: begin
        if (expired) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin values are derived from the next state so they change together with it.
    sclk_d = (state_d == HIGH);
    ncs_d  = !(state_d inside {SETUP, HIGH, LOW, HOLD});
    copi_d = ncs_d ? 1'b0 : shift_d[FRAME_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

`ifdef SPI_CFG_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb/tb_spi_cfg_master.sv - self-checking bench for spi_cfg_master with SPI target model
module tb_spi_cfg_master;

  localparam int N = 2;
  localparam int D = 4;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid = '0;
  logic [13:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        busy, done, SCLK, nCS, COPI;
  logic [0:0]  done_id;
`ifdef SPI_CFG_ADDR_CHECK_EN
  logic        addr_err;
`endif

  always #5 clk = ~clk;

  spi_cfg_master #(.N_REQ(N), .CLK_DIV(D), .CS_GAP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .SCLK      (SCLK),
    .nCS       (nCS),
    .COPI      (COPI)
`ifdef SPI_CFG_ADDR_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {logic [6:0] a; logic [7:0] d;} req_t;
  typedef struct {int id; logic [6:0] a; logic [7:0] d;} exp_t;

  // ---------------- requester driver ----------------
  req_t     pq0[$];
  req_t     pq1[$];
  bit [1:0] acc = '0;
  bit       rnd_mode = 0;

  task automatic push_req(input int i, input logic [6:0] a, input logic [7:0] d);
    req_t r;
    r.a = a;
    r.d = d;
    if (i == 0) pq0.push_back(r);
    else pq1.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (i == 0) void'(pq0.pop_front());
        else void'(pq1.pop_front());
        req_valid[i] = 1'b0;
      end else if (!req_valid[i] && ((i == 0) ? pq0.size() : pq1.size()) > 0 &&
                   (!rnd_mode || $urandom_range(0, 3) == 0)) begin
        req_t r;
        r = (i == 0) ? pq0[0] : pq1[0];
        req_addr[7*i +: 7] = r.a;
        req_data[8*i +: 8] = r.d;
        req_valid[i]       = 1'b1;
      end
    end
  end

  // ---------------- reference model + SPI target model ----------------
  int          cyc = 0;
  always @(posedge clk) cyc++;

  exp_t        expq[$];
  int          ptr_m = 0;
  bit          inflight = 0;
  int          idle_ok = 0;
  int          last_accept_cyc = 0;
  int          done_cyc = 0;
  int          accept_gap [N];
  int          done_count = 0;
  int          idlog[$];
  logic [15:0] last_frame = '0;
  logic [7:0]  tregs [5];
  logic [7:0]  mregs [5];
  bit          abort_ok = 0;
  int          gap_last = 0;
  int          rise_cyc = 0;
  int          err_count = 0;
  bit          err_pending = 0;
  int          err_cyc = 0;
  int          err_id = 0;

  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_copi = 1'b0;
  int          stable = 0, rises = 0, lowc = 0;
  logic [15:0] bits = '0;
  bit          copi_bad = 0;

  initial begin
    for (int k = 0; k < 5; k++) begin
      tregs[k] = 8'h00;
      mregs[k] = 8'h00;
    end
  end

  function automatic int rr_pick(input logic [1:0] v, input int p);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic exp_done;
    int   exp_id;
    exp_t e;
    exp_done = 1'b0;
    exp_id   = 0;

    // serial side
    stable = (COPI !== prev_copi) ? 1 : stable + 1;
    if (COPI !== prev_copi && SCLK) copi_bad = 1;
    if (prev_ncs && !nCS) begin
      chk("ncs_fall_after_accept", cyc, last_accept_cyc + 1);
      gap_last = cyc - rise_cyc;
      bits = '0; rises = 0; lowc = 0;
    end
    if (!nCS) lowc++;
    if (!nCS && SCLK && !prev_sclk) begin
      bits = {bits[14:0], COPI};
      rises++;
      chk("copi_stable_before_rise", stable > D, 1);
    end
    if (!prev_ncs && nCS) begin
      rise_cyc = cyc;
      if (abort_ok && rises < 16) begin
        abort_ok = 0;
        if (expq.size() > 0) void'(expq.pop_front());
        inflight = 0;
      end else begin
        chk("one_frame_expected", expq.size(), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("frame_bits", bits, {1'b1, e.a, e.d});
          chk("sclk_rises", rises, 16);
          chk("ncs_low_cycles", lowc, 33 * D);
          chk("copi_only_changes_sclk_low", copi_bad, 0);
          if (e.a <= 7'h04) mregs[e.a] = e.d;
          exp_done = 1'b1;
          exp_id   = e.id;
        end
        if (rises == 16 && bits[15] && bits[14:8] <= 7'h04) tregs[bits[14:8]] = bits[7:0];
        last_frame = bits;
        inflight   = 0;
        idle_ok    = cyc + G * D;
      end
      copi_bad = 0;
    end

`ifdef SPI_CFG_ADDR_CHECK_EN
    if (err_pending && cyc == err_cyc) begin
      exp_done    = 1'b1;
      exp_id      = err_id;
      err_pending = 0;
      idle_ok     = cyc;
    end
    chk("addr_err", addr_err, exp_done && !(!prev_ncs && nCS));
    if (addr_err) err_count++;
`endif
    chk("done", done, exp_done);
    if (exp_done) chk("done_id", done_id, exp_id);
    if (done) begin
      done_count++;
      done_cyc = cyc;
      idlog.push_back(int'(done_id));
    end

    // accept side
    if (req_ready != 2'b00) begin
      int ei;
      int ai;
      ei = rr_pick(req_valid, ptr_m);
      chk("grant_onehot", req_ready, (ei < 0) ? 2'b00 : 2'b01 << ei);
      chk("busy_at_accept", busy, 1);
      chk("no_accept_mid_frame", inflight, 0);
      chk("accept_not_before_idle", cyc >= idle_ok, 1);
      ai = req_ready[0] ? 0 : 1;
      acc[ai] = 1'b1;
      if (ei >= 0) begin
        e.id = ei;
        e.a  = req_addr[7*ei +: 7];
        e.d  = req_data[8*ei +: 8];
        ptr_m = (ei + 1) % N;
        accept_gap[ei] = cyc - done_cyc;
        last_accept_cyc = cyc;
`ifdef SPI_CFG_ADDR_CHECK_EN
        if (e.a > 7'h04) begin
          err_pending = 1;
          err_cyc     = cyc + 1;
          err_id      = ei;
        end else begin
          expq.push_back(e);
          inflight = 1;
        end
`else
        expq.push_back(e);
        inflight = 1;
`endif
      end
    end

    prev_ncs  = nCS;
    prev_sclk = SCLK;
    prev_copi = COPI;
  end

  // ---------------- test sequences ----------------
  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk("wait_done_in_budget", done_count >= target, 1);
  endtask

  typedef struct {
    int          req;
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base;
    int n;
    int k0;
    logic [7:0] saved;

    vecs[0] = '{req: 0, a: 7'h04, d: 8'hA5, frame: 16'h84A5};
    vecs[1] = '{req: 1, a: 7'h00, d: 8'h3C, frame: 16'h803C};
    vecs[2] = '{req: 0, a: 7'h03, d: 8'h81, frame: 16'h8381};
    vecs[3] = '{req: 1, a: 7'h7F, d: 8'h11, frame: 16'hFF11};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ncs", nCS, 1);
    chk("rst_sclk", SCLK, 0);
    chk("rst_copi", COPI, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ncs", nCS, 1);
    chk("idle_busy", busy, 0);

    // table-driven single writes
    for (int v = 0; v < 4; v++) begin
      base = done_count;
      push_req(vecs[v].req, vecs[v].a, vecs[v].d);
      wait_done(base + 1, 400);
      chk("vec_done_id", idlog[idlog.size()-1], vecs[v].req);
`ifdef SPI_CFG_ADDR_CHECK_EN
      if (vecs[v].a <= 7'h04) chk("vec_frame", last_frame, vecs[v].frame);
`else
      chk("vec_frame", last_frame, vecs[v].frame);
`endif
      if (vecs[v].a <= 7'h04) chk("vec_target_reg", tregs[vecs[v].a], vecs[v].d);
      repeat (12) @(negedge clk);
    end
    chk("pwm_duty_reg", tregs[4], 8'hA5);

    // simultaneous requests: req0 first, 8 GAP + 1 IDLE cycles between frames
    base = done_count;
    push_req(0, 7'h00, 8'h0F);
    push_req(1, 7'h01, 8'hF0);
    wait_done(base + 1, 400);
    chk("simul_first_frame", last_frame, 16'h800F);
    wait_done(base + 2, 400);
    chk("simul_second_frame", last_frame, 16'h81F0);
    chk("simul_ncs_high_gap", gap_last, G * D + 1);
    repeat (12) @(negedge clk);

    // fairness with both requesters kept busy
    base = done_count;
    k0 = idlog.size();
    for (int k = 0; k < 4; k++) begin
      push_req(0, 7'h00, 8'($urandom));
      push_req(1, 7'h01, 8'($urandom));
    end
    wait_done(base + 8, 1600);
    for (int k = 0; k < 8; k++) begin
      if (k0 + k < idlog.size()) chk("fair_order", idlog[k0+k], k % 2);
    end
    repeat (12) @(negedge clk);

    // request raised mid-frame waits for the first IDLE cycle
    base = done_count;
    push_req(0, 7'h03, 8'h5A);
    n = 0;
    while (!(nCS == 1'b0 && SCLK == 1'b1) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("midframe_reached_high", n < 200, 1);
    push_req(1, 7'h02, 8'h66);
    wait_done(base + 2, 500);
    chk("midframe_accept_first_idle", accept_gap[1], G * D);
    chk("midframe_reg", tregs[2], 8'h66);
    repeat (12) @(negedge clk);

    // reset after the 7th SCLK rise abandons the frame
    saved = tregs[2];
    push_req(0, 7'h02, 8'hC3);
    n = 0;
    while (nCS != 1'b0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    while (rises < 7 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    chk("reset_reached_7th_rise", n < 300, 1);
    base = done_count;
    abort_ok = 1;
    #1 rst_n = 1'b0;
    pq0.delete();
    pq1.delete();
    req_valid = '0;
    acc = '0;
    ptr_m = 0;
    idle_ok = 0;
    #1;
    chk("abort_ncs", nCS, 1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_copi", COPI, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_seen_by_target", abort_ok, 0);
    chk("abort_no_done", done_count, base);
    chk("abort_reg_unchanged", tregs[2], saved);
    push_req(1, 7'h01, 8'h99);
    push_req(0, 7'h02, 8'hC3);
    wait_done(base + 2, 500);
    chk("post_reset_rr_first", idlog[idlog.size()-2], 0);
    chk("post_reset_reg", tregs[2], 8'hC3);
    repeat (12) @(negedge clk);

`ifdef SPI_CFG_ADDR_CHECK_EN
    base = done_count;
    k0 = err_count;
    push_req(0, 7'h05, 8'hAA);
    wait_done(base + 1, 50);
    chk("addr_err_pulses", err_count, k0 + 1);
    push_req(0, 7'h04, 8'hBB);
    wait_done(base + 2, 400);
    chk("addr_ok_reg", tregs[4], 8'hBB);
    chk("addr_ok_no_err", err_count, k0 + 1);
    repeat (12) @(negedge clk);
`endif

    // randomized traffic against the model
    rnd_mode = 1;
    base = done_count;
    for (int k = 0; k < 30; k++) begin
      push_req($urandom_range(0, 1), 7'($urandom_range(0, 127)), 8'($urandom));
    end
    wait_done(base + 30, 30 * 200);
    repeat (12) @(negedge clk);
    for (int k = 0; k < 5; k++) chk("random_target_reg", tregs[k], mregs[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
